// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: note encoding, sequencer
// state enum, and the LFSR seed/taps plus its single-step function.
package simon_pkg;

    localparam int NOTE_W    = 3;
    localparam int NUM_NOTES = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    // Right-shifting Galois LFSR: the bit shifted out decides whether the
    // tap mask is folded into the shifted value.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [NUM_NOTES-1:0] note_to_onehot(input logic [NOTE_W-1:0] n);
        return NUM_NOTES'(1) << n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, steps every clock, reseeded by reset.
// Ports: clk, reset_n (async, active-low), q (current LFSR state).
module lfsr16
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Simon sequence store and player. Appends pseudo-random notes to a
// register file and plays them back as a one-hot note enable bus with a
// programmable tone length and a fixed silent gap after every note.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   clear/append/start    single-cycle commands, only honoured in IDLE
//   speed                 tone length = TONE_CYCLES*(speed+1), latched at start
//   note_onehot/note_idx  sounding note (zero when silent)
//   len/full              sequence length and capacity flag
//   busy/done             playback active / one-cycle end-of-playback pulse
//
// state | meaning
// IDLE  | waiting for a command, outputs silent
// TONE  | current note sounding, counter runs down the tone length
// GAP   | silence after a note, counter runs down GAP_CYCLES
module note_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int TONE_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       append,
    input  logic                       start,
    input  logic [1:0]                 speed,
    output logic [NUM_NOTES-1:0]       note_onehot,
    output logic [NOTE_W-1:0]          note_idx,
    output logic [$clog2(MAX_LEN):0]   len,
    output logic                       full,
    output logic                       busy,
    output logic                       done
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(4 * TONE_CYCLES);

    // The counter is loaded with length-1 and terminates at zero, so the
    // longest tone (4*TONE_CYCLES) fits in CNT_W bits.
    localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYCLES - 1);

    seq_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       tone_m1, tone_m1_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [LEN_W-1:0]       len_nxt;
    logic [NUM_NOTES-1:0]   onehot_nxt;
    logic [NOTE_W-1:0]      note_idx_nxt;
    logic                   full_nxt, busy_nxt, done_nxt;
    logic                   wr_en;
    logic [NOTE_W-1:0]      rd_note;
    logic [IDX_W-1:0]       rd_addr;
    logic [CNT_W-1:0]       start_tone_m1;

    logic [15:0]            lfsr_q;
    logic                   unused_lfsr_bits;

    logic [NOTE_W-1:0]      seq_mem [MAX_LEN];

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[15:NOTE_W];

    assign start_tone_m1 = CNT_W'(TONE_CYCLES * (int'(speed) + 1) - 1);

    // Only one read port is needed: note 0 at start, idx+1 when leaving GAP.
    assign rd_addr = (state == IDLE) ? '0 : idx + IDX_W'(1);
    assign rd_note = seq_mem[rd_addr];

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tone_m1_nxt  = tone_m1;
        idx_nxt      = idx;
        len_nxt      = len;
        onehot_nxt   = note_onehot;
        note_idx_nxt = note_idx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        wr_en        = 1'b0;

        case (state)
            IDLE: begin
                if (clear) begin
                    len_nxt = '0;
                end else if (append) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        len_nxt = len + LEN_W'(1);
                    end
                end else if (start) begin
                    if (len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        tone_m1_nxt  = start_tone_m1;
                        cnt_nxt      = start_tone_m1;
                        idx_nxt      = '0;
                        onehot_nxt   = note_to_onehot(rd_note);
                        note_idx_nxt = rd_note;
                        busy_nxt     = 1'b1;
                        state_nxt    = TONE;
                    end
                end
            end
            TONE: begin
                if (cnt == '0) begin
                    cnt_nxt      = GAP_M1;
                    onehot_nxt   = '0;
                    note_idx_nxt = '0;
                    state_nxt    = GAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if ({1'b0, idx} == len - LEN_W'(1)) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt      = idx + IDX_W'(1);
                        cnt_nxt      = tone_m1;
                        onehot_nxt   = note_to_onehot(rd_note);
                        note_idx_nxt = rd_note;
                        state_nxt    = TONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        full_nxt = (len_nxt == LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tone_m1     <= '0;
            idx         <= '0;
            len         <= '0;
            full        <= 1'b0;
            note_onehot <= '0;
            note_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tone_m1     <= tone_m1_nxt;
            idx         <= idx_nxt;
            len         <= len_nxt;
            full        <= full_nxt;
            note_onehot <= onehot_nxt;
            note_idx    <= note_idx_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Storage is deliberately not reset or cleared; len alone defines validity.
    // wr_en is only raised when not full, so len's low bits are a valid address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            seq_mem[len[IDX_W-1:0]] <= lfsr_q[NOTE_W-1:0];
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam int MAX_LEN = 32;
    localparam int TONE    = 4;
    localparam int GAP     = 2;
    localparam int LEN_W   = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic             append = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       speed = 2'd0;
    logic [7:0]       note_onehot;
    logic [2:0]       note_idx;
    logic [LEN_W-1:0] len;
    logic             full, busy, done;

    note_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .TONE_CYCLES (TONE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .append      (append),
        .start       (start),
        .speed       (speed),
        .note_onehot (note_onehot),
        .note_idx    (note_idx),
        .len         (len),
        .full        (full),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_seq[$];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR tracks the DUT's free-running generator clock by clock.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= galois(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_out(input logic [7:0] oh, input logic [2:0] ni,
                                             input logic b, input logic d, input logic [5:0] l);
        return {13'd0, oh, ni, b, d, l};
    endfunction

    // One IDLE-state command cycle; expectations come from the queue model.
    task automatic apply_cmd(input logic c, input logic a, input logic s, input string tag);
        logic exp_done;
        exp_done = 1'b0;
        clear = c; append = a; start = s;
        if (c) model_seq.delete();
        else if (a) begin
            if (model_seq.size() < MAX_LEN) model_seq.push_back(int'(m_lfsr[2:0]));
        end else if (s) begin
            if (model_seq.size() == 0) exp_done = 1'b1;
        end
        @(negedge clk);
        clear = 1'b0; append = 1'b0; start = 1'b0;
        check({tag, "_out"}, pack_out(note_onehot, note_idx, busy, done, len),
              pack_out(8'd0, 3'd0, 1'b0, exp_done, 6'(model_seq.size())));
        check({tag, "_full"}, 32'(full), 32'(model_seq.size() == MAX_LEN));
    endtask

    // Plays the stored sequence and compares every cycle to a waveform built
    // from the note list: tone cycles of 1<<note, then GAP silent cycles.
    task automatic play(input logic [1:0] spd, input logic [1:0] spd_mid, input bit poke, input string tag);
        logic [7:0] w_oh[$];
        logic [2:0] w_ni[$];
        int tone_len;
        int saved;
        tone_len = TONE * (int'(spd) + 1);
        saved = model_seq.size();
        foreach (model_seq[i]) begin
            repeat (tone_len) begin
                w_oh.push_back(8'(1 << model_seq[i]));
                w_ni.push_back(3'(model_seq[i]));
            end
            repeat (GAP) begin
                w_oh.push_back(8'd0);
                w_ni.push_back(3'd0);
            end
        end
        speed = spd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < w_oh.size(); k++) begin
            if (k == 2) speed = spd_mid;
            if (poke && k == 3) begin
                append = 1'b1; clear = 1'b1; start = 1'b1;
            end else begin
                append = 1'b0; clear = 1'b0; start = 1'b0;
            end
            check({tag, "_cyc"}, pack_out(note_onehot, note_idx, busy, done, len),
                  pack_out(w_oh[k], w_ni[k], 1'b1, 1'b0, 6'(saved)));
            @(negedge clk);
        end
        append = 1'b0; clear = 1'b0; start = 1'b0;
        check({tag, "_done"}, pack_out(note_onehot, note_idx, busy, done, len),
              pack_out(8'd0, 3'd0, 1'b0, 1'b1, 6'(saved)));
        @(negedge clk);
        check({tag, "_after"}, pack_out(note_onehot, note_idx, busy, done, len),
              pack_out(8'd0, 3'd0, 1'b0, 1'b0, 6'(saved)));
    endtask

    typedef struct {
        bit c;
        bit a;
        bit s;
        int exp_len;
        bit exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [15:0] ref_l;
        int saved_note;

        tbl[0] = '{c:0, a:0, s:1, exp_len:0, exp_done:1};
        tbl[1] = '{c:0, a:1, s:0, exp_len:1, exp_done:0};
        tbl[2] = '{c:0, a:1, s:0, exp_len:2, exp_done:0};
        tbl[3] = '{c:1, a:1, s:1, exp_len:0, exp_done:0};
        tbl[4] = '{c:0, a:1, s:1, exp_len:1, exp_done:0};
        tbl[5] = '{c:1, a:0, s:0, exp_len:0, exp_done:0};
        tbl[6] = '{c:0, a:0, s:0, exp_len:0, exp_done:0};
        tbl[7] = '{c:0, a:1, s:0, exp_len:1, exp_done:0};

        // Reset
        repeat (3) @(negedge clk);
        check("rst_out", pack_out(note_onehot, note_idx, busy, done, len), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        ref_l = 16'hACE1;
        for (int i = 0; i < 10; i++) ref_l = galois(ref_l);
        check("rst_lfsr10", 32'(dut.u_lfsr.q), 32'(ref_l));
        check("rst_idle10", pack_out(note_onehot, note_idx, busy, done, len), 32'd0);

        // Table-driven IDLE commands, starting from an empty sequence
        for (int i = 0; i < 8; i++) begin
            apply_cmd(tbl[i].c, tbl[i].a, tbl[i].s, "tbl");
            check("tbl_len", 32'(len), 32'(tbl[i].exp_len));
            check("tbl_done", 32'(done), 32'(tbl[i].exp_done));
            check("tbl_busy", 32'(busy), 32'd0);
        end

        // Append three notes and play at speed 0 (4-cycle tones, 2-cycle gaps)
        apply_cmd(1'b1, 1'b0, 1'b0, "clr");
        repeat (3) apply_cmd(1'b0, 1'b1, 1'b0, "app");
        play(2'd0, 2'd0, 1'b0, "play3");

        // Speed latched at start: 16-cycle tones despite mid-play change
        apply_cmd(1'b1, 1'b0, 1'b0, "clr");
        repeat (2) apply_cmd(1'b0, 1'b1, 1'b0, "app");
        play(2'd3, 2'd0, 1'b0, "spd");

        // Commands during playback are ignored
        play(2'd1, 2'd2, 1'b1, "poke");

        // Capacity: 33 appends, last one ignored
        apply_cmd(1'b1, 1'b0, 1'b0, "clr");
        repeat (33) apply_cmd(1'b0, 1'b1, 1'b0, "cap");
        check("cap_len", 32'(len), 32'd32);
        check("cap_full", 32'(full), 32'd1);
        for (int i = 0; i < MAX_LEN; i++)
            check("cap_mem", 32'(dut.seq_mem[i]), 32'(model_seq[i]));
        saved_note = model_seq[0];
        apply_cmd(1'b1, 1'b0, 1'b0, "cap_clr");
        check("cap_clr_len", 32'(len), 32'd0);
        check("cap_clr_full", 32'(full), 32'd0);
        check("mem_kept", 32'(dut.seq_mem[0]), 32'(saved_note));

        // Randomized command stream against the queue model
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (model_seq.size() >= 10) r = 0;
            if (r == 0)
                apply_cmd(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_clr");
            else if (r <= 5)
                apply_cmd(1'b0, 1'b1, 1'($urandom_range(0, 1)), "rnd_app");
            else if (model_seq.size() == 0)
                apply_cmd(1'b0, 1'b0, 1'b1, "rnd_st0");
            else
                play(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), "rnd_play");
        end

        // Reset asserted mid-TONE
        if (model_seq.size() == 0) apply_cmd(1'b0, 1'b1, 1'b0, "app");
        speed = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out", pack_out(note_onehot, note_idx, busy, done, len), 32'd0);
        check("midrst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        model_seq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        apply_cmd(1'b0, 1'b0, 1'b1, "post_rst_st0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
